// File: rtl/element_pkg.sv
// rtl/element_pkg.sv - shared sizing and saturation helpers for element combiners
// Contents:
//   ACC_W                   widest signed intermediate any combiner may hand to sat_dw()
//   SAMPLE_MAX/SAMPLE_MIN   clamp bounds of the default 16-bit sample
//   sum_levels(n)           adder-tree depth for n leaves
//   sat_dw(v, dw)           clamp v to the signed dw-bit range
package element_pkg;

  localparam int ACC_W     = 40;
  localparam int SAMPLE_DW = 16;
  localparam logic signed [SAMPLE_DW-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_DW-1:0] SAMPLE_MIN = 16'sh8000;

  function automatic int sum_levels(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_dw(input logic signed [ACC_W-1:0] v,
                                                     input int dw);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (ACC_W'(1) << (dw - 1)) - ACC_W'(1);
    lo = ~hi;  // two's complement: ~(2^(dw-1)-1) == -2^(dw-1)
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/element_addtree.sv
// rtl/element_addtree.sv - one-component, one-slice pipelined signed adder tree
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   leaf_i  in   NIN signed W-bit leaves, leaf n at [n*W +: W]
//   root_o  out  signed sum, W+LEVELS bits, LEVELS cycles after leaf_i
module element_addtree
  import element_pkg::*;
#(
  parameter  int NIN    = 4,
  parameter  int W      = 16,
  localparam int LEVELS = sum_levels(NIN),
  localparam int OW     = W + LEVELS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIN*W-1:0] leaf_i,
  output logic [OW-1:0]   root_o
);

  localparam int NPAD = 1 << LEVELS;

  // Level l holds NPAD>>l nodes of W+l bits; level 0 is the unregistered leaf row.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = NPAD >> l;
    localparam int LW  = W + l;
    logic [CNT*LW-1:0] node;

    if (l == 0) begin : g_leaf
      // Absent leaves (NIN < NPAD) sit in the upper bits and are zero-filled.
      assign node = (CNT*LW)'(leaf_i);
    end else begin : g_add
      localparam int PW = LW - 1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node <= '0;
        end else begin
          for (int k = 0; k < CNT; k++) begin
            node[k*LW +: LW] <= LW'($signed(g_lvl[l-1].node[2*k*PW +: PW]))
                              + LW'($signed(g_lvl[l-1].node[(2*k+1)*PW +: PW]));
          end
        end
      end
    end
  end

  assign root_o = g_lvl[LEVELS].node;

endmodule

// File: rtl/element_sumn.sv
// rtl/element_sumn.sv - N-element pipelined output combiner with mask, saturation and overflow monitor
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   valid_in[NELEM]       per-element sample valid
//   multix_in/multiy_in   element i at [i*NSLICE*DW +: NSLICE*DW], slice s at [s*DW +: DW]
//   enable_mask[NELEM]    1 = element included in the sum
//   ovf_clr               single-cycle clear of ovf_sticky/ovf_count
//   valid, multix, multiy summed output, LEVELS+2 cycles after input
//   postprobusy[NELEM]    per-element busy feedback
//   ovf_sticky, ovf_count overflow seen since clear / valid overflow cycles (saturating)
module element_sumn
  import element_pkg::*;
#(
  parameter int NELEM  = 4,
  parameter int NSLICE = 4,
  parameter int DW     = 16,
  parameter bit SAT    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NELEM-1:0]          valid_in,
  input  logic [NELEM*NSLICE*DW-1:0] multix_in,
  input  logic [NELEM*NSLICE*DW-1:0] multiy_in,
  input  logic [NELEM-1:0]          enable_mask,
  input  logic                      ovf_clr,
  output logic                      valid,
  output logic [NSLICE*DW-1:0]      multix,
  output logic [NSLICE*DW-1:0]      multiy,
  output logic [NELEM-1:0]          postprobusy,
  output logic                      ovf_sticky,
  output logic [15:0]               ovf_count
);

  localparam int LEVELS = sum_levels(NELEM);
  localparam int LAT    = LEVELS + 2;
  localparam int RW     = DW + LEVELS;
  localparam int NTREE  = 2 * NSLICE;
  localparam int EW     = NSLICE * DW;

  logic [NELEM*EW-1:0] x0_d, y0_d, x0_q, y0_q;
  logic [LAT-1:0]      valid_pipe_q;

  // Mask applied at the input register only.
  always_comb begin
    x0_d = '0;
    y0_d = '0;
    for (int i = 0; i < NELEM; i++) begin
      x0_d[i*EW +: EW] = enable_mask[i] ? multix_in[i*EW +: EW] : '0;
      y0_d[i*EW +: EW] = enable_mask[i] ? multiy_in[i*EW +: EW] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q         <= '0;
      y0_q         <= '0;
      valid_pipe_q <= '0;
    end else begin
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      valid_pipe_q <= {valid_pipe_q[LAT-2:0], |(valid_in & enable_mask)};
    end
  end

  // Trees 0..NSLICE-1 carry x slices, NSLICE..2*NSLICE-1 carry y slices.
  logic [NTREE-1:0][RW-1:0] root;
  logic [NTREE-1:0][DW-1:0] out_d;
  logic [NTREE-1:0]         ovf_t;

  for (genvar t = 0; t < NTREE; t++) begin : g_tree
    localparam int S = t % NSLICE;
    logic [NELEM*DW-1:0]     leaf;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] clamped;

    always_comb begin
      leaf = '0;
      for (int i = 0; i < NELEM; i++) begin
        leaf[i*DW +: DW] = (t < NSLICE) ? x0_q[i*EW + S*DW +: DW] : y0_q[i*EW + S*DW +: DW];
      end
    end

    element_addtree #(.NIN(NELEM), .W(DW)) u_tree (
      .clk    (clk),
      .rst_n  (reset),
      .leaf_i (leaf),
      .root_o (root[t])
    );

    assign ext      = ACC_W'($signed(root[t]));
    assign clamped  = sat_dw(ext, DW);
    // Clamping changes the value exactly when the root lies outside DW range.
    assign ovf_t[t] = (clamped != ext);
    assign out_d[t] = SAT ? clamped[DW-1:0] : ext[DW-1:0];
  end

  logic [NTREE*DW-1:0] out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign valid  = valid_pipe_q[LAT-1];
  assign multix = out_q[EW-1:0];
  assign multiy = out_q[2*EW-1:EW];

  // Root data aligns with valid_pipe_q[LAT-2]; counters update on the edge
  // that loads the output register, so they move together with valid.
  logic        ovf_hit;
  logic        ovf_sticky_d, ovf_sticky_q;
  logic [15:0] ovf_count_d, ovf_count_q;

  assign ovf_hit = valid_pipe_q[LAT-2] & (|ovf_t);

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (ovf_clr) begin
      ovf_sticky_d = ovf_hit;
      ovf_count_d  = {15'd0, ovf_hit};
    end else if (ovf_hit) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

  // Gated by reset so busy drops immediately even while valid_in is held.
  assign postprobusy = reset ? (valid_in | (enable_mask & {NELEM{|valid_pipe_q}})) : '0;

endmodule
